rmi_sched_reader: RTL

RMI_SCHED_READER -- requirements
Module: rmi_sched_reader

---
 rtl/rmi_sched_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rmi_sched_reader.sv
// Streams DEPTH schedule words per frame from one of two BRAMs into a 2-entry
// output FIFO with ready/valid back-pressure; reads are credit-limited so the FIFO never overflows.
module rmi_sched_reader #(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        selMem,
  input  logic        start,
  output logic        rdEn1,
  output logic [31:0] rdAdd1,
  input  logic [31:0] rdData1,
  output logic        rdEn2,
  output logic [31:0] rdAdd2,
  input  logic [31:0] rdData2,
  output logic        outValid,
  output logic [31:0] outData,
  input  logic        outReady,
  output logic        busy,
  output logic        done,
  output logic [15:0] frameCnt
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q;
  logic              bank_q;
  logic [15:0]       addr_q;
  logic [31:0]       last_add_q;
  logic              inflight_q;
  logic [15:0]       frame_cnt_q;

  logic [1:0][31:0]  fifo_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;

  logic              push;
  logic              pop;
  logic [2:0]        load;
  logic              issue;
  logic              fin;
  logic [31:0]       rd_word;
  logic [31:0]       cur_add;

  assign push = inflight_q;
  assign pop  = (occ_q != 2'd0) && outReady;

  // A pop this cycle frees a slot before the next push lands, which is what
  // lets the pipeline sustain one word per cycle with only two entries.
  assign load  = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
  assign issue = (state_q == READ) && (load < 3'd2);
  assign fin   = (state_q == DRAIN) && !inflight_q && (occ_q == 2'd0);

  assign occ_d   = occ_q + {1'b0, push} - {1'b0, pop};
  assign rd_word = bank_q ? rdData2 : rdData1;
  assign cur_add = issue ? {16'h0000, addr_q} : last_add_q;

  assign rdEn1    = issue && !bank_q;
  assign rdEn2    = issue && bank_q;
  assign rdAdd1   = bank_q ? 32'h0 : cur_add;
  assign rdAdd2   = bank_q ? cur_add : 32'h0;
  assign outValid = (occ_q != 2'd0);
  assign outData  = outValid ? fifo_q[rd_ptr_q] : 32'h0;
  assign busy     = (state_q != IDLE);
  assign done     = fin;
  assign frameCnt = frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bank_q      <= 1'b0;
      addr_q      <= 16'h0;
      last_add_q  <= 32'h0;
      inflight_q  <= 1'b0;
      frame_cnt_q <= 16'h0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        IDLE: begin
          if (start) begin
            bank_q     <= selMem;
            addr_q     <= 16'h0;
            last_add_q <= 32'h0;
            state_q    <= READ;
          end
        end
        READ: begin
          if (issue) begin
            addr_q     <= addr_q + 16'd1;
            last_add_q <= {16'h0000, addr_q};
            if (addr_q == 16'(DEPTH - 1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fin) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= rd_word;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
    end
  end

endmodule
